// File: rtl/bus_pkg.sv
// bus_pkg: shared serial-bus types and constants
package bus_pkg;
  localparam int ADDRESS_WIDTH = 15;
  localparam int DATA_WIDTH = 8;
  localparam int DEFAULT_MASTER_COUNT = 4;
  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_e;
endpackage

// File: rtl/serial_bus_arbiter_if.sv
// serial_bus_arbiter_if: request/grant bundle between bus masters and the arbiter
// req/slave_busy flow master->arbiter; grant/grant_id/bus_busy/timeout_pulse flow back.
interface serial_bus_arbiter_if #(
  parameter int MASTER_COUNT = bus_pkg::DEFAULT_MASTER_COUNT,
  parameter int MASTER_ID_WIDTH = $clog2(MASTER_COUNT)
);
  logic [MASTER_COUNT-1:0] req;
  logic slave_busy;
  logic [MASTER_COUNT-1:0] grant;
  logic [MASTER_ID_WIDTH-1:0] grant_id;
  logic bus_busy;
  logic timeout_pulse;
  modport slave (input req, slave_busy, output grant, grant_id, bus_busy, timeout_pulse);
  modport master (output req, slave_busy, input grant, grant_id, bus_busy, timeout_pulse);
endinterface

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: round-robin winner search starting after last
// Ports: req_i requests, last_i previous winner, win_o chosen index, valid_o any request.
module rr_priority_picker #(
  parameter int MASTER_COUNT = 4,
  parameter int MASTER_ID_WIDTH = $clog2(MASTER_COUNT)
) (
  input  logic [MASTER_COUNT-1:0] req_i,
  input  logic [MASTER_ID_WIDTH-1:0] last_i,
  output logic [MASTER_ID_WIDTH-1:0] win_o,
  output logic valid_o
);
  int k;
  // Scan farthest-first so the nearest set bit after last_i overwrites and wins.
  always_comb begin
    k = 0;
    win_o = '0;
    for (int i = MASTER_COUNT; i >= 1; i--) begin
      k = (int'(last_i) + i) % MASTER_COUNT;
      if (req_i[k]) win_o = k[MASTER_ID_WIDTH-1:0];
    end
  end
  assign valid_o = |req_i;
endmodule

// File: rtl/serial_bus_arbiter.sv
// serial_bus_arbiter: round-robin owner of the shared serial data bus
// Ports: clk, rst (async active-high), bus (slave modport: req, slave_busy in;
// grant, grant_id, bus_busy, timeout_pulse out, all registered).
// Optional forced release after TIMEOUT_CYCLES idle grant cycles: SERIAL_BUS_ARBITER_TIMEOUT_EN.
module serial_bus_arbiter import bus_pkg::*; #(
  parameter int MASTER_COUNT = DEFAULT_MASTER_COUNT,
  parameter int MASTER_ID_WIDTH = $clog2(MASTER_COUNT),
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_WIDTH = 8
) (
  input logic clk,
  input logic rst,
  serial_bus_arbiter_if.slave bus
);
  state_e state_q, state_d;
  logic [MASTER_COUNT-1:0] grant_q, grant_d;
  logic [MASTER_ID_WIDTH-1:0] gid_q, gid_d, last_q, last_d, win;
  logic busy_q, busy_d, tp_q, tp_d, valid, expire;
  rr_priority_picker #(.MASTER_COUNT(MASTER_COUNT), .MASTER_ID_WIDTH(MASTER_ID_WIDTH)) u_pick (
    .req_i(bus.req),
    .last_i(last_q),
    .win_o(win),
    .valid_o(valid)
  );
`ifdef SERIAL_BUS_ARBITER_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
  // Counts non-busy grant cycles; cleared whenever no grant is held.
  assign cnt_d = (state_q != GRANT) ? '0 : bus.slave_busy ? cnt_q : cnt_q + 1'b1;
  assign expire = !bus.slave_busy && (cnt_q + 1'b1 == TIMEOUT_WIDTH'(TIMEOUT_CYCLES));
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_WIDTH'(TIMEOUT_CYCLES);
  assign expire = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gid_d = gid_q;
    busy_d = busy_q;
    last_d = last_q;
    tp_d = 1'b0;
    if (state_q == GRANT) begin
      if (!bus.slave_busy && (!bus.req[gid_q] || expire)) begin
        state_d = GAP;
        grant_d = '0;
        busy_d = 1'b0;
        tp_d = expire;
      end
    end else if (valid) begin
      state_d = GRANT;
      grant_d = MASTER_COUNT'(1) << win;
      gid_d = win;
      busy_d = 1'b1;
      last_d = win;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      gid_q <= '0;
      busy_q <= 1'b0;
      tp_q <= 1'b0;
      last_q <= MASTER_ID_WIDTH'(MASTER_COUNT - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gid_q <= gid_d;
      busy_q <= busy_d;
      tp_q <= tp_d;
      last_q <= last_d;
    end
  assign bus.grant = grant_q;
  assign bus.grant_id = gid_q;
  assign bus.bus_busy = busy_q;
  assign bus.timeout_pulse = tp_q;
endmodule

// File: tb/tb_serial_bus_arbiter.sv
// tb_serial_bus_arbiter: directed checks of grant order, busy hold, reset and timeout
module tb_serial_bus_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_run = 0;
  int n_fail = 0;
  serial_bus_arbiter_if #(.MASTER_COUNT(4)) bus ();
  serial_bus_arbiter #(.MASTER_COUNT(4), .TIMEOUT_CYCLES(10), .TIMEOUT_WIDTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_g(input string tag, input logic [3:0] g, input logic [1:0] id, input logic bb);
    chk({tag, "_grant"}, 32'(bus.grant), 32'(g));
    chk({tag, "_id"}, 32'(bus.grant_id), 32'(id));
    chk({tag, "_busy"}, 32'(bus.bus_busy), 32'(bb));
  endtask
  initial begin
    bus.req = 4'b0000;
    bus.slave_busy = 1'b0;
    tick();
    tick();
    chk_g("rst", 4'b0000, 2'd0, 1'b0);
    chk("rst_tp", 32'(bus.timeout_pulse), 32'd0);
    rst = 1'b0;
    tick();
    chk_g("idle", 4'b0000, 2'd0, 1'b0);
    bus.req = 4'b1111;
    tick();
    chk_g("rr0", 4'b0001, 2'd0, 1'b1);
    bus.req = 4'b1110;
    tick();
    chk_g("gap0", 4'b0000, 2'd0, 1'b0);
    bus.req = 4'b1111;
    tick();
    chk_g("rr1", 4'b0010, 2'd1, 1'b1);
    bus.req = 4'b1101;
    tick();
    chk("gap1", 32'(bus.grant), 32'd0);
    bus.req = 4'b1111;
    tick();
    chk_g("rr2", 4'b0100, 2'd2, 1'b1);
    bus.req = 4'b1011;
    tick();
    chk("gap2", 32'(bus.grant), 32'd0);
    bus.req = 4'b1111;
    tick();
    chk_g("rr3", 4'b1000, 2'd3, 1'b1);
    bus.req = 4'b0000;
    tick();
    chk_g("gap3", 4'b0000, 2'd3, 1'b0);
    tick();
    bus.req = 4'b0100;
    tick();
    chk_g("bh_grant", 4'b0100, 2'd2, 1'b1);
    bus.req = 4'b0000;
    bus.slave_busy = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      chk("bh_hold", 32'(bus.grant), 32'b0100);
    end
    bus.slave_busy = 1'b0;
    tick();
    chk_g("bh_rel", 4'b0000, 2'd2, 1'b0);
    tick();
    bus.req = 4'b0010;
    tick();
    chk_g("np_grant", 4'b0010, 2'd1, 1'b1);
    bus.req = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("np_hold", 32'(bus.grant), 32'b0010);
    end
    bus.req = 4'b0001;
    tick();
    chk("np_gap", 32'(bus.grant), 32'd0);
    tick();
    chk_g("np_next", 4'b0001, 2'd0, 1'b1);
    bus.req = 4'b0100;
    tick();
    chk("mr_gap", 32'(bus.grant), 32'd0);
    tick();
    chk_g("mr_grant", 4'b0100, 2'd2, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("mr_async_grant", 32'(bus.grant), 32'd0);
    chk("mr_async_busy", 32'(bus.bus_busy), 32'd0);
    bus.req = 4'b1010;
    tick();
    rst = 1'b0;
    tick();
    chk_g("mr_after", 4'b0010, 2'd1, 1'b1);
    bus.req = 4'b0000;
    tick();
    tick();
    chk_g("to_idle", 4'b0000, 2'd1, 1'b0);
    bus.req = 4'b1000;
    tick();
    chk_g("to_grant", 4'b1000, 2'd3, 1'b1);
    bus.req = 4'b1001;
    for (int i = 1; i < 10; i++) begin
      tick();
      chk("to_hold", 32'(bus.grant), 32'b1000);
      chk("to_tp_low", 32'(bus.timeout_pulse), 32'd0);
    end
`ifdef SERIAL_BUS_ARBITER_TIMEOUT_EN
    tick();
    chk_g("to_rel", 4'b0000, 2'd3, 1'b0);
    chk("to_tp", 32'(bus.timeout_pulse), 32'd1);
    tick();
    chk_g("to_next", 4'b0001, 2'd0, 1'b1);
    chk("to_tp_end", 32'(bus.timeout_pulse), 32'd0);
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("nto_hold", 32'(bus.grant), 32'b1000);
      chk("nto_tp", 32'(bus.timeout_pulse), 32'd0);
    end
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
